// File: rtl/keypad_pkg.sv
// Purpose: shared types, key codes and one-hot row/column constants for the keypad scanner.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    localparam logic [3:0] ROW_1    = 4'b1000;
    localparam logic [3:0] ROW_2    = 4'b0100;
    localparam logic [3:0] ROW_3    = 4'b0010;
    localparam logic [3:0] ROW_4    = 4'b0001;
    localparam logic [3:0] ROW_NONE = 4'b0000;

    localparam logic [2:0] COL_L    = 3'b100;
    localparam logic [2:0] COL_M    = 3'b010;
    localparam logic [2:0] COL_R    = 3'b001;
    localparam logic [2:0] COL_NONE = 3'b000;

    // Key index layout in the frame map: idx = row*3 + col, row 0 = top, col 0 = left.
    function automatic logic [1:0] key_row(input logic [3:0] idx);
        logic [1:0] r;
        if (idx < 4'd3)      r = 2'd0;
        else if (idx < 4'd6) r = 2'd1;
        else if (idx < 4'd9) r = 2'd2;
        else                 r = 2'd3;
        return r;
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] idx);
        logic [1:0] c;
        case (idx)
            4'd0, 4'd3, 4'd6, 4'd9:  c = 2'd0;
            4'd1, 4'd4, 4'd7, 4'd10: c = 2'd1;
            default:                 c = 2'd2;
        endcase
        return c;
    endfunction

    // Bottom row is '*', '0', '#'; the other rows are plain digits 1-9.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = KEY_0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Purpose: bundles the keypad matrix lines and the decoded-key outputs of the scanner.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must sample the one-cycle pulses when they occur.
interface keypad_scanner_if;
    logic [3:0] linha_drive_out;
    logic [2:0] coluna_raw_in;
    logic [2:0] coluna_out;
    logic [3:0] linha_out;
    logic [3:0] key_code_out;
    logic       key_valid_out;
    logic       key_release_out;
    logic       key_held_out;

    modport master (
        output linha_drive_out,
        input  coluna_raw_in,
        output coluna_out,
        output linha_out,
        output key_code_out,
        output key_valid_out,
        output key_release_out,
        output key_held_out
    );

    modport slave (
        input  linha_drive_out,
        output coluna_raw_in,
        input  coluna_out,
        input  linha_out,
        input  key_code_out,
        input  key_valid_out,
        input  key_release_out,
        input  key_held_out
    );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Purpose: generic two-flop synchronizer for asynchronous level inputs.
// Latency: 2 cycles.
// Backpressure: none.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops to let metastability resolve before use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x3 keypad, debounces, rejects ghost presses, presents a stable key.
// Latency: outputs change 1 cycle after the committing frame end; press/release take DEBOUNCE_FRAMES..+1 frames.
// Backpressure: none; valid/release are one-cycle pulses, key fields hold for the whole press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 128
) (
    input  logic              clock_in,
    input  logic              reset_in,
    keypad_scanner_if.master  kp
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    // The increment that would reach DEBOUNCE_FRAMES is the commit itself,
    // so the counter never needs to hold DEBOUNCE_FRAMES.
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [SW-1:0] slot_q;
    logic [3:0]    linha_drive_q;
    logic [11:0]   map_q;
    logic [2:0]    col_sync;

    logic          slot_last;
    logic          frame_end;
    logic [11:0]   sample_map;
    logic [11:0]   frame_map;
    logic [1:0]    cand_ones;
    logic [3:0]    cand_idx;
    logic          cand_single;

    kp_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    acc_q, acc_d;
    logic [2:0]    coluna_q, coluna_d;
    logic [3:0]    linha_q, linha_d;
    logic [3:0]    code_q, code_d;
    logic          held_q, held_d;
    logic          valid_q, valid_d;
    logic          release_q, release_d;

    sync2 #(.WIDTH(3)) u_col_sync (
        .clk_i  (clock_in),
        .rst_ni (reset_in),
        .d_i    (kp.coluna_raw_in),
        .q_o    (col_sync)
    );

    assign slot_last = (slot_q == SLOT_LAST);
    assign frame_end = slot_last && linha_drive_q[0];

    // Slot timer and one-hot row rotation; the row advances after the last slot cycle.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            slot_q        <= '0;
            linha_drive_q <= ROW_1;
        end else if (slot_last) begin
            slot_q        <= '0;
            linha_drive_q <= {linha_drive_q[0], linha_drive_q[3:1]};
        end else begin
            slot_q        <= slot_q + SW'(1);
        end
    end

    // Place the synchronized columns into the map bits of the row currently driven.
    always_comb begin
        sample_map = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                sample_map[r*3 + c] = linha_drive_q[3 - r] & col_sync[2 - c];
            end
        end
    end

    assign frame_map = map_q | sample_map;

    // Accumulate one frame of samples; cleared when the frame is evaluated.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            map_q <= '0;
        end else if (frame_end) begin
            map_q <= '0;
        end else if (slot_last) begin
            map_q <= frame_map;
        end
    end

    // Classify the frame: count set bits (saturating at 2) and remember the key index.
    always_comb begin
        cand_ones = 2'd0;
        cand_idx  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (frame_map[i]) begin
                if (cand_ones != 2'd2) begin
                    cand_ones = cand_ones + 2'd1;
                end
                cand_idx = 4'(i);
            end
        end
    end

    // Multiple keys (possible ghosting) are indistinguishable from no key.
    assign cand_single = (cand_ones == 2'd1);

    // Debounce FSM state and output registers.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            acc_q     <= '0;
            coluna_q  <= COL_NONE;
            linha_q   <= ROW_NONE;
            code_q    <= KEY_NONE;
            held_q    <= 1'b0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            acc_q     <= acc_d;
            coluna_q  <= coluna_d;
            linha_q   <= linha_d;
            code_q    <= code_d;
            held_q    <= held_d;
            valid_q   <= valid_d;
            release_q <= release_d;
        end
    end

    // Next-state and output logic; every decision is taken at frame end only.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        acc_d     = acc_q;
        coluna_d  = coluna_q;
        linha_d   = linha_q;
        code_d    = code_q;
        held_d    = held_q;
        valid_d   = 1'b0;
        release_d = 1'b0;

        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (cand_single) begin
                        pend_d  = cand_idx;
                        cnt_d   = CNT_ONE;
                        state_d = ST_DEB_PRESS;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!cand_single) begin
                        state_d = ST_IDLE;
                    end else if (cand_idx != pend_q) begin
                        pend_d = cand_idx;
                        cnt_d  = CNT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        acc_d    = pend_q;
                        coluna_d = COL_L >> key_col(pend_q);
                        linha_d  = ROW_1 >> key_row(pend_q);
                        code_d   = key_code(key_row(pend_q), key_col(pend_q));
                        held_d   = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = ST_PRESSED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!(cand_single && cand_idx == acc_q)) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_DEB_RELEASE;
                    end
                end
                ST_DEB_RELEASE: begin
                    if (cand_single && cand_idx == acc_q) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        coluna_d  = COL_NONE;
                        linha_d   = ROW_NONE;
                        code_d    = KEY_NONE;
                        held_d    = 1'b0;
                        release_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign kp.linha_drive_out = linha_drive_q;
    assign kp.coluna_out      = coluna_q;
    assign kp.linha_out       = linha_q;
    assign kp.key_code_out    = code_q;
    assign kp.key_held_out    = held_q;
    assign kp.key_valid_out   = valid_q;
    assign kp.key_release_out = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: directed scoreboard bench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_FRAMES=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SD    = 8;
    localparam int DF    = 4;
    localparam int FRAME = 4 * SD;

    typedef struct {
        bit         rel;
        logic [3:0] code;
        logic [2:0] col;
        logic [3:0] row;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp ();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clock_in (clk),
        .reset_in (rst_n),
        .kp       (kp)
    );

    // Keypad model: two independent contacts, each closing its column when its row is driven.
    logic       k_on  [2];
    logic [3:0] k_row [2];
    logic [2:0] k_col [2];

    assign kp.coluna_raw_in = ((k_on[0] && kp.linha_drive_out == k_row[0]) ? k_col[0] : 3'b000)
                            | ((k_on[1] && kp.linha_drive_out == k_row[1]) ? k_col[1] : 3'b000);

    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  glitch_err = 0;
    ev_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] model_code(input logic [3:0] row, input logic [2:0] col);
        case ({row, col})
            7'b1000_100: return 4'h1;
            7'b1000_010: return 4'h2;
            7'b1000_001: return 4'h3;
            7'b0100_100: return 4'h4;
            7'b0100_010: return 4'h5;
            7'b0100_001: return 4'h6;
            7'b0010_100: return 4'h7;
            7'b0010_010: return 4'h8;
            7'b0010_001: return 4'h9;
            7'b0001_100: return 4'hA;
            7'b0001_010: return 4'h0;
            7'b0001_001: return 4'hB;
            default:     return 4'hF;
        endcase
    endfunction

    function automatic ev_t mk_valid(input logic [3:0] row, input logic [2:0] col);
        ev_t e;
        e.rel  = 1'b0;
        e.row  = row;
        e.col  = col;
        e.code = model_code(row, col);
        return e;
    endfunction

    function automatic ev_t mk_release();
        ev_t e;
        e.rel  = 1'b1;
        e.row  = 4'b0000;
        e.col  = 3'b000;
        e.code = 4'hF;
        return e;
    endfunction

    // Monitor: every pulse is matched against the scoreboard; key fields must always be coherent.
    always @(negedge clk) begin
        if (rst_n) begin
            if (kp.key_valid_out && kp.key_release_out) glitch_err++;
            if (kp.key_held_out) begin
                if (kp.key_code_out !== model_code(kp.linha_out, kp.coluna_out) ||
                    kp.key_code_out === 4'hF) glitch_err++;
            end else if (kp.key_code_out !== 4'hF || kp.coluna_out !== 3'b000 ||
                         kp.linha_out !== 4'b0000) begin
                glitch_err++;
            end
            if (kp.key_valid_out || kp.key_release_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {kp.key_valid_out, kp.key_release_out}, 2'b00);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {kp.key_valid_out, kp.key_release_out}, e.rel ? 2'b01 : 2'b10);
                    check("pulse_code", kp.key_code_out, e.code);
                    check("pulse_col",  kp.coluna_out,   e.col);
                    check("pulse_row",  kp.linha_out,    e.row);
                end
            end
        end
    end

    task automatic wait_drain(input string tag, input int budget, output int lat);
        lat = 0;
        while (exp_q.size() != 0 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_code"}, kp.key_code_out, 4'hF);
        check({tag, "_col"},  kp.coluna_out,   3'b000);
        check({tag, "_row"},  kp.linha_out,    4'b0000);
        check({tag, "_held"}, kp.key_held_out, 1'b0);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish, pass %0d total %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int elapsed;
        int d;
        logic on;

        k_on[0] = 1'b0; k_row[0] = ROW_1; k_col[0] = COL_L;
        k_on[1] = 1'b0; k_row[1] = ROW_1; k_col[1] = COL_L;

        // Reset values while held in reset, then row rotation timing.
        repeat (3) @(negedge clk);
        check("rst_drive", kp.linha_drive_out, 4'b1000);
        check_idle_outputs("rst");
        check("rst_flags", {kp.key_valid_out, kp.key_release_out}, 2'b00);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("drive_slot0_end", kp.linha_drive_out, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        check("drive_slot1", kp.linha_drive_out, 4'b0100);

        // Clean press and release of '5'.
        repeat (5) @(negedge clk);
        k_row[0] = ROW_2; k_col[0] = COL_M; k_on[0] = 1'b1;
        exp_q.push_back(mk_valid(ROW_2, COL_M));
        wait_drain("press5", 6 * FRAME, lat);
        check("press5_latency", (lat >= 3 * FRAME && lat <= 5 * FRAME + 4), 1'b1);
        @(negedge clk);
        check("held5_code", kp.key_code_out, 4'h5);
        check("held5_col",  kp.coluna_out,   3'b010);
        check("held5_row",  kp.linha_out,    4'b0100);
        check("held5_held", kp.key_held_out, 1'b1);
        k_on[0] = 1'b0;
        exp_q.push_back(mk_release());
        wait_drain("rel5", 6 * FRAME, lat);
        @(negedge clk);
        check_idle_outputs("rel5");

        // Bounce on '#': toggle every 1-2 frames for 10 frames, then hold.
        k_row[0] = ROW_4; k_col[0] = COL_R;
        elapsed = 0;
        on = 1'b1;
        while (elapsed < 10) begin
            d = $urandom_range(1, 2);
            k_on[0] = on;
            repeat (d * FRAME) @(negedge clk);
            elapsed += d;
            on = ~on;
        end
        check("bounce_no_accept", kp.key_held_out, 1'b0);
        k_on[0] = 1'b1;
        exp_q.push_back(mk_valid(ROW_4, COL_R));
        wait_drain("hash", 8 * FRAME, lat);
        @(negedge clk);
        check("hash_code", kp.key_code_out, 4'hB);
        k_on[0] = 1'b0;
        exp_q.push_back(mk_release());
        wait_drain("rel_hash", 6 * FRAME, lat);

        // Ghost: '1' and '9' together are rejected; '1' alone is then accepted.
        k_row[0] = ROW_1; k_col[0] = COL_L; k_on[0] = 1'b1;
        k_row[1] = ROW_3; k_col[1] = COL_R; k_on[1] = 1'b1;
        repeat (8 * FRAME) @(negedge clk);
        check_idle_outputs("ghost");
        k_on[1] = 1'b0;
        exp_q.push_back(mk_valid(ROW_1, COL_L));
        wait_drain("ghost1", 6 * FRAME, lat);
        @(negedge clk);
        check("ghost1_code", kp.key_code_out, 4'h1);
        k_on[0] = 1'b0;
        exp_q.push_back(mk_release());
        wait_drain("rel1", 6 * FRAME, lat);

        // Slide from '0' to '*' with no gap.
        k_row[0] = ROW_4; k_col[0] = COL_M; k_on[0] = 1'b1;
        exp_q.push_back(mk_valid(ROW_4, COL_M));
        wait_drain("zero", 6 * FRAME, lat);
        @(negedge clk);
        check("zero_code", kp.key_code_out, 4'h0);
        k_col[0] = COL_L;
        exp_q.push_back(mk_release());
        exp_q.push_back(mk_valid(ROW_4, COL_L));
        wait_drain("slide", 12 * FRAME, lat);
        @(negedge clk);
        check("star_code", kp.key_code_out, 4'hA);
        k_on[0] = 1'b0;
        exp_q.push_back(mk_release());
        wait_drain("rel_star", 6 * FRAME, lat);

        // Reset while '7' is held: immediate clear, no release, re-accept after DF frames.
        k_row[0] = ROW_3; k_col[0] = COL_L; k_on[0] = 1'b1;
        exp_q.push_back(mk_valid(ROW_3, COL_L));
        wait_drain("seven", 6 * FRAME, lat);
        repeat (3) @(negedge clk);
        check("seven_held", kp.key_held_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        check("mid_rst_drive", kp.linha_drive_out, 4'b1000);
        check("mid_rst_pulses", {kp.key_valid_out, kp.key_release_out}, 2'b00);
        repeat (3) @(negedge clk);
        exp_q.push_back(mk_valid(ROW_3, COL_L));
        rst_n = 1'b1;
        lat = 0;
        while (lat < 8 * FRAME) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (kp.key_valid_out) break;
        end
        check("rearm_latency", lat, DF * FRAME);
        wait_drain("rearm", 2, lat);
        k_on[0] = 1'b0;
        exp_q.push_back(mk_release());
        wait_drain("rel7", 6 * FRAME, lat);

        repeat (4) @(negedge clk);
        check("coherence_errors", glitch_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
